// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin front end that time-shares one 32-bit
// ripple-carry adder between NUM_REQ requesters. One add is in flight at a
// time. The sum is sampled after a CALC_CYCLES settle window and returned
// on a valid/ready response channel tagged with the owner's index.

module ripple_carry_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  // Bit-serial carry chain; carry out of the MSB is deliberately not exported.
  always_comb begin : ripple
    logic carry;
    carry = 1'b0;
    sum_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
  end

endmodule

module adder_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 32,
  parameter int CALC_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [WIDTH-1:0]           resp_sum,
  output logic                       resp_cout,
  output logic                       busy
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int CNT_W = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;

  localparam logic [IDW:0]   NUM_REQ_W = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CALC_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             resp_valid_q, resp_valid_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_sum_q, resp_sum_d;
  logic             resp_cout_q, resp_cout_d;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW:0]     cand;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  // Single shared adder, fed only from the captured operand registers.
  ripple_carry_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a_i   (op_a_q),
    .b_i   (op_b_q),
    .sum_o (add_sum)
  );

  // Carry out reconstructed from the operand MSBs and the sum MSB.
  assign add_cout = (op_a_q[WIDTH-1] & op_b_q[WIDTH-1]) |
                    ((op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1]) & ~add_sum[WIDTH-1]);

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // Grant strobe exists only in IDLE, and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == S_IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  // Next-state logic for the IDLE -> CALC -> RESP operation sequence.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_sum_d   = resp_sum_q;
    resp_cout_d  = resp_cout_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          op_a_d   = req_a[grant_idx*WIDTH +: WIDTH];
          op_b_d   = req_b[grant_idx*WIDTH +: WIDTH];
          id_d     = grant_idx;
          rr_ptr_d = (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
          cnt_d    = CNT_LOAD;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        if (cnt_q == '0) begin
          resp_sum_d   = add_sum;
          resp_cout_d  = add_cout;
          resp_id_d    = id_q;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; async reset drops any in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_sum_q   <= '0;
      resp_cout_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_sum_q   <= resp_sum_d;
      resp_cout_q  <= resp_cout_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_sum   = resp_sum_q;
  assign resp_cout  = resp_cout_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: a table of single operations,
// then hand-written fairness, backpressure, reset and settle-window runs.

module tb_adder_share_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_a, req_b;
  logic         resp_valid, resp_ready, resp_cout, busy;
  logic [1:0]   resp_id;
  logic [31:0]  resp_sum;

  logic [3:0]   req_valid4, req_ready4;
  logic [127:0] req_a4, req_b4;
  logic         resp_valid4, resp_ready4, resp_cout4, busy4;
  logic [1:0]   resp_id4;
  logic [31:0]  resp_sum4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_share_arbiter #(.NUM_REQ(4), .WIDTH(32), .CALC_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_sum(resp_sum), .resp_cout(resp_cout), .busy(busy)
  );

  adder_share_arbiter #(.NUM_REQ(4), .WIDTH(32), .CALC_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_a(req_a4), .req_b(req_b4),
    .req_ready(req_ready4), .resp_valid(resp_valid4), .resp_ready(resp_ready4),
    .resp_id(resp_id4), .resp_sum(resp_sum4), .resp_cout(resp_cout4), .busy(busy4)
  );

  typedef struct {
    logic [3:0]  vmask;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  exp_ready;
    logic [1:0]  exp_id;
    logic [31:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fill the owner's lane with the operands and other lanes with junk.
  task automatic load_lanes(input int owner, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = (i == owner) ? a : (32'hDEAD_0000 | 32'(i));
      req_b[i*32 +: 32] = (i == owner) ? b : (32'h0BAD_0000 | 32'(i));
    end
  endtask

  initial begin
    vecs[0] = '{4'b0100, 32'h0000_0005, 32'h0000_0007, 4'b0100, 2'd2, 32'h0000_000C, 1'b0};
    vecs[1] = '{4'b0001, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0001, 2'd0, 32'h0000_0000, 1'b1};
    vecs[2] = '{4'b0010, 32'h8000_0000, 32'h8000_0000, 4'b0010, 2'd1, 32'h0000_0000, 1'b1};
    vecs[3] = '{4'b1000, 32'h7FFF_FFFF, 32'h0000_0001, 4'b1000, 2'd3, 32'h8000_0000, 1'b0};
    vecs[4] = '{4'b1001, 32'h1234_5678, 32'h1111_1111, 4'b0001, 2'd0, 32'h2345_6789, 1'b0};
    vecs[5] = '{4'b1001, 32'hFFFF_0000, 32'h0002_0000, 4'b1000, 2'd3, 32'h0001_0000, 1'b1};

    rst_n = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    req_valid4 = '0; req_a4 = '0; req_b4 = '0; resp_ready4 = 1'b1;
    #2;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_sum",        resp_sum,        32'd0);
    chk("rst_id",         32'(resp_id),    32'd0);
    chk("rst_cout",       32'(resp_cout),  32'd0);
    chk("rst_ready",      32'(req_ready),  32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Table-driven single operations.
    for (int v = 0; v < 6; v++) begin
      req_valid = vecs[v].vmask;
      load_lanes(int'(vecs[v].exp_id), vecs[v].a, vecs[v].b);
      #1;
      chk($sformatf("v%0d_ready", v), 32'(req_ready), 32'(vecs[v].exp_ready));
      step();
      req_valid = '0;
      chk($sformatf("v%0d_calc_valid", v), 32'(resp_valid), 32'd0);
      chk($sformatf("v%0d_calc_busy", v),  32'(busy),       32'd1);
      step();
      chk($sformatf("v%0d_valid", v), 32'(resp_valid), 32'd1);
      chk($sformatf("v%0d_id", v),    32'(resp_id),    32'(vecs[v].exp_id));
      chk($sformatf("v%0d_sum", v),   resp_sum,        vecs[v].exp_sum);
      chk($sformatf("v%0d_cout", v),  32'(resp_cout),  32'(vecs[v].exp_cout));
      step();
      chk($sformatf("v%0d_done", v), 32'(resp_valid), 32'd0);
      chk($sformatf("v%0d_idle", v), 32'(busy),       32'd0);
    end

    // Fairness: all valid, rr_ptr is back at 0 after vector 5.
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = 32'h1000_0000 * (i + 1) + 32'(i);
      req_b[i*32 +: 32] = 32'h0000_0100 + 32'(i);
    end
    req_valid = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      int e;
      e = n % 4;
      #1;
      chk($sformatf("fair%0d_ready", n), 32'(req_ready), 32'(4'b0001 << e));
      step();
      chk($sformatf("fair%0d_calc_ready", n), 32'(req_ready), 32'd0);
      step();
      chk($sformatf("fair%0d_id", n),  32'(resp_id), 32'(e));
      chk($sformatf("fair%0d_sum", n), resp_sum,
          32'h1000_0000 * (e + 1) + 32'(e) + 32'h0000_0100 + 32'(e));
      step();
    end

    // Backpressure: rr_ptr=0, only requester 1 asks.
    req_valid = 4'b0010;
    load_lanes(1, 32'd100, 32'd200);
    resp_ready = 1'b0;
    #1;
    chk("bp_grant", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b1111;
    step();
    chk("bp_valid0", 32'(resp_valid), 32'd1);
    for (int n = 0; n < 5; n++) begin
      step();
      chk($sformatf("bp%0d_valid", n), 32'(resp_valid), 32'd1);
      chk($sformatf("bp%0d_id", n),    32'(resp_id),    32'd1);
      chk($sformatf("bp%0d_sum", n),   resp_sum,        32'd300);
      chk($sformatf("bp%0d_ready", n), 32'(req_ready),  32'd0);
    end
    resp_ready = 1'b1;
    step();
    chk("bp_release_valid", 32'(resp_valid), 32'd0);
    chk("bp_release_busy",  32'(busy),       32'd0);
    chk("bp_hold_sum",      resp_sum,        32'd300);
    chk("bp_hold_id",       32'(resp_id),    32'd1);
    chk("bp_next_grant",    32'(req_ready),  32'b0100);
    step();

    // Reset while requester 2's operation is in CALC.
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  32'(busy),       32'd0);
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_sum",   resp_sum,        32'd0);
    chk("mid_rst_id",    32'(resp_id),    32'd0);
    chk("mid_rst_ready", 32'(req_ready),  32'd0);
    req_valid = '0;
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      chk($sformatf("post_rst%0d_valid", n), 32'(resp_valid), 32'd0);
      chk($sformatf("post_rst%0d_busy", n),  32'(busy),       32'd0);
    end
    req_valid = 4'b1010;
    load_lanes(1, 32'h0000_0040, 32'h0000_0002);
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    step();
    chk("post_rst_id",  32'(resp_id), 32'd1);
    chk("post_rst_sum", resp_sum,     32'h0000_0042);
    step();

    // Settle window on the CALC_CYCLES=4 instance, requester 1 only.
    begin
      int seed;
      logic [31:0] a, b;
      logic [32:0] ref_sum;
      int lat;
      seed = 7;
      for (int n = 0; n < 10; n++) begin
        a = $random(seed);
        b = $random(seed);
        ref_sum = {1'b0, a} + {1'b0, b};
        req_a4 = '0; req_b4 = '0;
        req_a4[32 +: 32] = a;
        req_b4[32 +: 32] = b;
        req_valid4 = 4'b0010;
        #1;
        chk($sformatf("cc4_%0d_grant", n), 32'(req_ready4), 32'b0010);
        step();
        req_valid4 = '0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
          if (lat == 0 && resp_valid4) lat = c;
          if (lat == 0) step();
        end
        chk($sformatf("cc4_%0d_latency", n), 32'(lat), 32'd5);
        chk($sformatf("cc4_%0d_sum", n),  resp_sum4,         ref_sum[31:0]);
        chk($sformatf("cc4_%0d_cout", n), 32'(resp_cout4),   32'(ref_sum[32]));
        chk($sformatf("cc4_%0d_id", n),   32'(resp_id4),     32'd1);
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
